type3n_dot: RTL and testbench

//  Systolic N-lane dot-product engine: each valid input beat carries IMG_NB image samples that are

---
 rtl/type3n_dot.sv | 201 ++++++++++++++++++++
 tb/tb_type3n_dot.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/type3n_dot.sv
// Systolic IMG_NB-lane signed dot product with a double-buffered, commit-coherent kernel.
// Optional output clamp to the image sample range is enabled by defining CONV_SATURATE_EN.
module type3n_dot #(
  parameter  int IMG_WIDTH = 16,
  parameter  int KER_WIDTH = 8,
  parameter  int IMG_NB    = 3,
  parameter  int PIPELINE  = 2,
  localparam int OUT_WIDTH = IMG_WIDTH + KER_WIDTH + $clog2(IMG_NB) + 1,
  localparam int LATENCY   = PIPELINE * IMG_NB + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [IMG_WIDTH*IMG_NB-1:0]   img,
  input  logic                          val,
  input  logic [KER_WIDTH-1:0]          ker_data,
  input  logic                          ker_wr,
  input  logic                          ker_commit,
  output logic [OUT_WIDTH-1:0]          result,
  output logic                          result_val
);

  localparam int PROD_WIDTH = IMG_WIDTH + KER_WIDTH;

  logic signed [KER_WIDTH-1:0] r_shadow     [IMG_NB];
  logic signed [KER_WIDTH-1:0] w_shadow_nxt [IMG_NB];
  logic        [LATENCY-1:0]   r_vpipe;
  logic signed [OUT_WIDTH-1:0] w_psum       [IMG_NB+1];
  logic signed [OUT_WIDTH-1:0] w_res_nxt;
  logic signed [OUT_WIDTH-1:0] r_result;
  logic                        r_result_val;

  // Shadow kernel next value; the commit path sees this so a same-cycle write is included
  always_comb begin
    for (int k = 0; k < IMG_NB; k++) begin
      w_shadow_nxt[k] = r_shadow[k];
    end
    for (int k = 0; k < IMG_NB - 1; k++) begin
      if (ker_wr) begin
        w_shadow_nxt[k] = r_shadow[k+1];
      end else begin
        w_shadow_nxt[k] = r_shadow[k];
      end
    end
    if (ker_wr) begin
      w_shadow_nxt[IMG_NB-1] = ker_data;
    end else begin
      w_shadow_nxt[IMG_NB-1] = r_shadow[IMG_NB-1];
    end
  end

  // Shadow kernel register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < IMG_NB; k++) begin
        r_shadow[k] <= '0;
      end
    end else begin
      for (int k = 0; k < IMG_NB; k++) begin
        r_shadow[k] <= w_shadow_nxt[k];
      end
    end
  end

  // Valid tag pipe, aligned with the datapath up to the last cell output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vpipe <= '0;
    end else begin
      r_vpipe <= {r_vpipe[LATENCY-2:0], val};
    end
  end

  assign w_psum[0] = '0;

  for (genvar k = 0; k < IMG_NB; k++) begin : g_lane
    localparam int DLY = PIPELINE * k;

    logic signed [IMG_WIDTH-1:0]  r_img_sr [DLY+1];
    logic signed [KER_WIDTH-1:0]  r_ker_act;
    logic signed [OUT_WIDTH-1:0]  r_cell   [PIPELINE];
    logic signed [PROD_WIDTH-1:0] w_prod;
    logic        [OUT_WIDTH-1:0]  w_prod_ext;
    logic        [OUT_WIDTH-1:0]  w_sum;

    // Input register plus PIPELINE*k skew stages so lane k meets its partial sum
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= DLY; j++) begin
          r_img_sr[j] <= '0;
        end
      end else begin
        r_img_sr[0] <= img[k*IMG_WIDTH +: IMG_WIDTH];
        for (int j = 1; j <= DLY; j++) begin
          r_img_sr[j] <= r_img_sr[j-1];
        end
      end
    end

    if (DLY == 0) begin : g_commit_direct
      // Lane 0 takes the committed coefficient on the commit edge itself
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ker_act <= '0;
        end else if (ker_commit) begin
          r_ker_act <= w_shadow_nxt[k];
        end else begin
          r_ker_act <= r_ker_act;
        end
      end
    end else begin : g_commit_delayed
      logic                        r_cm_v [DLY];
      logic signed [KER_WIDTH-1:0] r_cm_c [DLY];

      // Each commit carries its own coefficient copy, so overlapping commits stay ordered
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < DLY; j++) begin
            r_cm_v[j] <= 1'b0;
            r_cm_c[j] <= '0;
          end
          r_ker_act <= '0;
        end else begin
          r_cm_v[0] <= ker_commit;
          r_cm_c[0] <= w_shadow_nxt[k];
          for (int j = 1; j < DLY; j++) begin
            r_cm_v[j] <= r_cm_v[j-1];
            r_cm_c[j] <= r_cm_c[j-1];
          end
          if (r_cm_v[DLY-1]) begin
            r_ker_act <= r_cm_c[DLY-1];
          end else begin
            r_ker_act <= r_ker_act;
          end
        end
      end
    end

    assign w_prod     = r_img_sr[DLY] * r_ker_act;
    assign w_prod_ext = {{(OUT_WIDTH-PROD_WIDTH){w_prod[PROD_WIDTH-1]}}, w_prod};
    assign w_sum      = w_psum[k] + w_prod_ext;

    // MAC cell: adder followed by PIPELINE partial-sum registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < PIPELINE; j++) begin
          r_cell[j] <= '0;
        end
      end else begin
        r_cell[0] <= w_sum;
        for (int j = 1; j < PIPELINE; j++) begin
          r_cell[j] <= r_cell[j-1];
        end
      end
    end

    assign w_psum[k+1] = r_cell[PIPELINE-1];
  end

`ifdef CONV_SATURATE_EN
  localparam logic signed [OUT_WIDTH-1:0] SAT_MAX =
    {{(OUT_WIDTH-IMG_WIDTH+1){1'b0}}, {(IMG_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] SAT_MIN =
    {{(OUT_WIDTH-IMG_WIDTH+1){1'b1}}, {(IMG_WIDTH-1){1'b0}}};

  // Clamp to the image sample range, result stays sign-extended to OUT_WIDTH
  always_comb begin
    w_res_nxt = w_psum[IMG_NB];
    if (w_psum[IMG_NB] > SAT_MAX) begin
      w_res_nxt = SAT_MAX;
    end else if (w_psum[IMG_NB] < SAT_MIN) begin
      w_res_nxt = SAT_MIN;
    end else begin
      w_res_nxt = w_psum[IMG_NB];
    end
  end
`else
  // Full-precision result, no clamp
  always_comb begin
    w_res_nxt = w_psum[IMG_NB];
  end
`endif

  // Output register: result only moves on tagged beats, otherwise it holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result     <= '0;
      r_result_val <= 1'b0;
    end else begin
      r_result_val <= r_vpipe[LATENCY-1];
      if (r_vpipe[LATENCY-1]) begin
        r_result <= w_res_nxt;
      end else begin
        r_result <= r_result;
      end
    end
  end

  assign result     = r_result;
  assign result_val = r_result_val;

endmodule

// File: tb/tb_type3n_dot.sv
// Directed self-checking bench for type3n_dot at default parameters.
// Expected values follow CONV_SATURATE_EN when it is defined for the build.
module tb_type3n_dot;

  localparam int IW = 16;
  localparam int KW = 8;
  localparam int NB = 3;
  localparam int OW = IW + KW + $clog2(NB) + 1;

`ifdef CONV_SATURATE_EN
  localparam longint EXP_SIGNED = -32768;
  localparam longint EXP_SATP   = 32767;
  localparam longint EXP_SATN   = -32768;
`else
  localparam longint EXP_SIGNED = -4174316;
  localparam longint EXP_SATP   = 12484227;
  localparam longint EXP_SATN   = -12484608;
`endif

  logic              clk;
  logic              rst_n;
  logic [IW*NB-1:0]  img;
  logic              val;
  logic [KW-1:0]     ker_data;
  logic              ker_wr;
  logic              ker_commit;
  logic [OW-1:0]     result;
  logic              result_val;

  int n_checks;
  int n_fail;

  type3n_dot dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .img        (img),
    .val        (val),
    .ker_data   (ker_data),
    .ker_wr     (ker_wr),
    .ker_commit (ker_commit),
    .result     (result),
    .result_val (result_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IW*NB-1:0] pk(input int a, input int b, input int c);
    return {c[IW-1:0], b[IW-1:0], a[IW-1:0]};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_ker(input int a, input int b, input int c);
    ker_wr = 1'b1;
    ker_data = a[KW-1:0]; tick(1);
    ker_data = b[KW-1:0]; tick(1);
    ker_data = c[KW-1:0]; tick(1);
    ker_wr = 1'b0;
    ker_commit = 1'b1; tick(1);
    ker_commit = 1'b0;
  endtask

  task automatic one_beat(input logic [IW*NB-1:0] v, input longint expv, input string tag);
    img = v; val = 1'b1;
    tick(1);
    val = 1'b0; img = pk(9, 9, 9);
    tick(6);
    chk({tag, "_early"}, result_val, 0);
    tick(1);
    chk({tag, "_rv"}, result_val, 1);
    chk({tag, "_res"}, $signed(result), expv);
    tick(1);
    chk({tag, "_rvoff"}, result_val, 0);
    chk({tag, "_hold"}, $signed(result), expv);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; img = '0; val = 1'b0;
    ker_data = '0; ker_wr = 1'b0; ker_commit = 1'b0;
    tick(3);
    chk("reset_result", $signed(result), 0);
    chk("reset_val", result_val, 0);
    rst_n = 1'b1;
    tick(2);

    // basic single beat
    load_ker(1, 2, 3);
    tick(3);
    one_beat(pk(2, 3, 1), 11, "basic");

    // three back-to-back beats, 20 idle, one more; idle lanes carry other data
    for (int c = 0; c < 32; c++) begin
      val = (c < 3 || c == 23);
      img = val ? pk(2, 3, 1) : pk(7, 7, 7);
      tick(1);
      chk($sformatf("burst_rv_%0d", c), result_val, (c == 7 || c == 8 || c == 9 || c == 30) ? 1 : 0);
      chk($sformatf("burst_res_%0d", c), $signed(result), 11);
    end
    val = 1'b0;

    // signed extremes
    load_ker(-4, -128, 127);
    tick(4);
    one_beat(pk(-5, 100, -32768), EXP_SIGNED, "signed");

    // commit lands on the middle beat of a burst
    load_ker(1, 2, 3);
    ker_wr = 1'b1;
    ker_data = 8'd0; tick(1);
    ker_data = 8'd0; tick(1);
    ker_data = 8'd1; tick(1);
    ker_wr = 1'b0;
    tick(4);
    img = pk(2, 3, 1); val = 1'b1;
    tick(1);
    ker_commit = 1'b1; tick(1);
    ker_commit = 1'b0; tick(1);
    val = 1'b0; img = pk(7, 7, 7);
    tick(4);
    chk("midcommit_early", result_val, 0);
    tick(1); chk("midcommit_b0", $signed(result), 11);
    tick(1); chk("midcommit_b1", $signed(result), 1);
    tick(1); chk("midcommit_b2", $signed(result), 1);
    chk("midcommit_b2_rv", result_val, 1);
    tick(1); chk("midcommit_end", result_val, 0);

    // write with commit in the same cycle, then two commits on consecutive edges
    ker_wr = 1'b1; ker_data = 8'd5; ker_commit = 1'b1; tick(1);
    ker_wr = 1'b0; ker_commit = 1'b0;
    tick(4);
    img = pk(1, 1, 1); val = 1'b1;
    tick(1);
    ker_wr = 1'b1; ker_data = 8'd2; ker_commit = 1'b1; tick(1);
    ker_data = 8'd3; tick(1);
    ker_wr = 1'b0; ker_commit = 1'b0; tick(1);
    val = 1'b0; img = pk(7, 7, 7);
    tick(4);
    chk("dblcommit_0", $signed(result), 6);
    tick(1); chk("dblcommit_1", $signed(result), 8);
    tick(1); chk("dblcommit_2", $signed(result), 10);
    tick(1); chk("dblcommit_3", $signed(result), 10);

    // range extremes, clamped only when saturation is built in
    load_ker(127, 127, 127);
    tick(4);
    one_beat(pk(32767, 32767, 32767), EXP_SATP, "sat_pos");
    one_beat(pk(-32768, -32768, -32768), EXP_SATN, "sat_neg");

    // reset with beats in flight
    load_ker(1, 2, 3);
    tick(4);
    img = pk(2, 3, 1); val = 1'b1;
    tick(3);
    val = 1'b0;
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("inflight_rst_result", $signed(result), 0);
    chk("inflight_rst_val", result_val, 0);
    tick(1);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      chk($sformatf("post_rst_rv_%0d", c), result_val, 0);
    end
    one_beat(pk(2, 3, 1), 0, "kernel_cleared");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
